// File: rtl/reg_transfer_sequencer_pkg.sv
// Shared definitions for the register-transfer sequencer: opcodes, unit
// enable indices, FSM state encoding and small decode helpers.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package reg_transfer_sequencer_pkg;

  // Opcodes carried in IR[15:12]; every other value is illegal.
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MOV   = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_HALT  = 4'hF
  } opcode_e;

  // Register load-enable bit positions inside o_unit_ien.
  typedef enum logic [3:0] {
    EN_IR  = 4'd0,
    EN_PC  = 4'd1,
    EN_AR  = 4'd2,
    EN_DR0 = 4'd3,
    EN_DR1 = 4'd4,
    EN_CR  = 4'd5
  } unit_en_e;

  // Special bus-driver positions inside o_unit_oen.
  localparam logic [3:0] FETCH_OEN = 4'd11;  // fetch data onto bus, PC increments
  localparam logic [3:0] LOAD_OEN  = 4'd12;  // load data onto bus

  // Highest legal source (core bus drivers 0..10) and destination index.
  localparam logic [3:0] MAX_SRC = 4'd10;
  localparam logic [3:0] MAX_DST = EN_CR;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEMWAIT = 3'd4,
    ST_HALTED  = 3'd5,
    ST_FAULT   = 3'd6
  } seq_state_e;

  // Internal snapshot of the sequencer, handy for probing from outside.
  typedef struct packed {
    seq_state_e  state;
    logic        ack;
    logic [7:0]  wait_count;
  } seq_dbg_t;

  // One-hot vector with bit idx set.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  // Load enable for a destination index. The PC only advances through the
  // fetch path, so a destination of PC never produces a load enable.
  function automatic logic [15:0] load_enable(input logic [3:0] dst);
    load_enable = onehot16(dst) & ~onehot16(EN_PC);
  endfunction

  // Opcode and operand legality check applied while the IR is valid.
  function automatic logic op_legal(input logic [3:0] op,
                                    input logic [3:0] src,
                                    input logic [3:0] dst);
    case (op)
      OP_NOP, OP_HALT: op_legal = 1'b1;
      OP_MOV:          op_legal = (src <= MAX_SRC) && (dst <= MAX_DST);
      OP_LOAD:         op_legal = (dst <= MAX_DST);
      OP_STORE:        op_legal = (src <= MAX_SRC);
      default:         op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_transfer_sequencer_wait_timer.sv
// Memory wait timer: counts request cycles without an acknowledge.
module seq_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] count,
  output logic       expired
);

  // Count while enabled, restart on clear, stop at the terminal value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

  // 255 request cycles have gone by without an acknowledge.
  assign expired = (count == 8'hFF);

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Register-transfer sequencer: fetches an instruction word, decodes it and
// drives one-hot unit enables and a memory request for NOP/MOV/LOAD/STORE.
//
// All outputs are registered. A memory acknowledge taken at a clock edge
// produces its enable pulse (fetch: oen[11]+ien[0], load: oen[12]+ien[dst])
// in the cycle that follows that edge, with o_mem_req already dropped.
//
// Memory handshake: o_mem_req is held high until a cycle in which
// i_mem_ready=1; that cycle completes the transfer. i_mem_ready is ignored
// whenever o_mem_req=0. o_mem_we is meaningful only while o_mem_req=1.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module reg_transfer_sequencer
  import reg_transfer_sequencer_pkg::*;
#(
  parameter int DW = `DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_halt,
  input  logic [DW-1:0] i_instruction,
  input  logic          i_mem_ready,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [15:0]   o_unit_ien,
  output logic [15:0]   o_unit_oen,
  output logic          o_busy,
  output logic          o_fault,
  output logic [15:0]   o_retired
);

  seq_state_e  state_q;
  logic        ack_q;       // enable-pulse phase after a memory acknowledge
  logic        req_q;
  logic        we_q;
  logic        busy_q;
  logic        fault_q;
  logic [15:0] ien_q;
  logic [15:0] oen_q;
  logic [15:0] retired_q;
  logic [3:0]  op_q;
  logic [3:0]  src_q;
  logic [3:0]  dst_q;

  logic [3:0]  ir_op;
  logic [3:0]  ir_src;
  logic [3:0]  ir_dst;
  logic        mem_ack;
  logic        timer_clear;
  logic        timer_expired;
  logic [7:0]  wait_count;
  logic        unused_ir;
  seq_dbg_t    dbg_unused;

  // IR fields; only consulted in DECODE, then latched for EXEC/MEMWAIT.
  assign ir_op  = i_instruction[15:12];
  assign ir_src = i_instruction[11:8];
  assign ir_dst = i_instruction[7:4];
  assign unused_ir = ^i_instruction;

  // An acknowledge only counts while a request is outstanding.
  assign mem_ack = req_q & i_mem_ready;

  // The timer restarts whenever no request is pending or one completes, so
  // every new request (including back-to-back ones) starts from zero.
  assign timer_clear = ~req_q | i_mem_ready;

  seq_wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (req_q),
    .count   (wait_count),
    .expired (timer_expired)
  );

  assign dbg_unused = {state_q, ack_q, wait_count};

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
      ien_q     <= 16'h0000;
      oen_q     <= 16'h0000;
      retired_q <= 16'h0000;
      op_q      <= 4'h0;
      src_q     <= 4'h0;
      dst_q     <= 4'h0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (i_start) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (ack_q) begin
            ack_q   <= 1'b0;
            ien_q   <= 16'h0000;
            oen_q   <= 16'h0000;
            state_q <= ST_DECODE;
          end else if (mem_ack) begin
            req_q <= 1'b0;
            ack_q <= 1'b1;
            oen_q <= onehot16(FETCH_OEN);
            ien_q <= onehot16(EN_IR);
          end else if (timer_expired) begin
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end
        end

        ST_DECODE: begin
          if (i_halt || (ir_op == OP_HALT)) begin
            busy_q  <= 1'b0;
            state_q <= ST_HALTED;
          end else if (!op_legal(ir_op, ir_src, ir_dst)) begin
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end else begin
            op_q    <= ir_op;
            src_q   <= ir_src;
            dst_q   <= ir_dst;
            state_q <= ST_EXEC;
            if (ir_op == OP_MOV) begin
              oen_q <= onehot16(ir_src);
              ien_q <= load_enable(ir_dst);
            end
          end
        end

        ST_EXEC: begin
          if (op_q == OP_LOAD) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            state_q <= ST_MEMWAIT;
          end else if (op_q == OP_STORE) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            oen_q   <= onehot16(src_q);
            state_q <= ST_MEMWAIT;
          end else begin
            oen_q     <= 16'h0000;
            ien_q     <= 16'h0000;
            retired_q <= retired_q + 16'd1;
            req_q     <= 1'b1;
            state_q   <= ST_FETCH;
          end
        end

        ST_MEMWAIT: begin
          if (ack_q) begin
            ack_q     <= 1'b0;
            ien_q     <= 16'h0000;
            oen_q     <= 16'h0000;
            retired_q <= retired_q + 16'd1;
            req_q     <= 1'b1;
            state_q   <= ST_FETCH;
          end else if (mem_ack) begin
            if (op_q == OP_STORE) begin
              we_q      <= 1'b0;
              oen_q     <= 16'h0000;
              retired_q <= retired_q + 16'd1;
              state_q   <= ST_FETCH;
            end else begin
              req_q <= 1'b0;
              ack_q <= 1'b1;
              oen_q <= onehot16(LOAD_OEN);
              ien_q <= load_enable(dst_q);
            end
          end else if (timer_expired) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            oen_q   <= 16'h0000;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end
        end

        ST_FAULT: begin
          state_q <= ST_FAULT;
        end

        default: begin
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          ien_q   <= 16'h0000;
          oen_q   <= 16'h0000;
          busy_q  <= 1'b0;
          fault_q <= 1'b1;
          state_q <= ST_FAULT;
        end
      endcase
    end
  end

  assign o_mem_req  = req_q;
  assign o_mem_we   = we_q;
  assign o_unit_ien = ien_q;
  assign o_unit_oen = oen_q;
  assign o_busy     = busy_q;
  assign o_fault    = fault_q;
  assign o_retired  = retired_q;

endmodule
